regfile_pc_sb: RTL and testbench
================================

// Module: regfile_pc_sb
// PURPOSE
//  Parametrised register file for the Rissy core. It has one write port, two read
//  ports with write-to-read bypass, a dedicated program-counter register with
//  increment and jump load, and a per-register pending-write scoreboard.
//  Sits between decode (read, issue) and writeback (write, clear busy).
//  Fully synchronous on clk; replaces the latch-style register file.
// PARAMETERS
//  DATA_W    16      register / PC width in bits
//  NUM_REGS  8       total registers including PC; power of two, >= 4
//  ADDR_W    3       $clog2(NUM_REGS); must match NUM_REGS
//  PC_IDX    7       register index aliased to the PC (NUM_REGS-1)
//  PC_STEP   2       PC increment per pc_inc
//  PC_RESET  0       PC value after reset
//  ZERO_R0   0       1: r0 reads 0, ignores writes, never busy
//  INIT_IDX  1       1: GPR i resets to i; 0: GPRs reset to 0
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-high
//  w_en       in   1       writeback strobe
//  w_addr     in   ADDR_W  writeback register index
//  w_data     in   DATA_W  writeback data
//  ra_addr    in   ADDR_W  read port A index
//  rb_addr    in   ADDR_W  read port B index
//  ra_data    out  DATA_W  read port A data (combinational)
//  rb_data    out  DATA_W  read port B data (combinational)
//  pc         out  DATA_W  current PC (registered)
//  pc_inc     in   1       advance PC by PC_STEP
//  pc_load    in   1       jump: load pc_target
//  pc_target  in   DATA_W  jump target
//  sb_set     in   1       instruction issued; mark sb_addr pending
//  sb_addr    in   ADDR_W  destination register being issued
//  ra_busy    out  1       ra_addr has an unresolved pending write
//  rb_busy    out  1       rb_addr has an unresolved pending write
// BEHAVIOUR
//  - Reset (rst=1 at posedge) initialises all state:
//    - GPR i = INIT_IDX ? i : 0.
//    - PC = PC_RESET.
//    - Busy bits = 0.
//    - rst overrides every other input in that cycle; asserting it mid-sequence discards pending writes.
//  - Write: on a posedge with w_en=1, the register at w_addr takes w_data (one-cycle latency).
//    - w_addr==PC_IDX writes the PC only when pc_load=0 and pc_inc=0; otherwise the write is dropped.
//    - When ZERO_R0=1, a write to r0 is dropped.
//  - Read: ra_data = bypass ? w_data : reg[ra_addr]; port B is identical.
//    - bypass = w_en & (w_addr==ra_addr) & not dropped.
//    - When ZERO_R0=1, ra_addr==0 returns 0.
//    - ra_addr==PC_IDX returns the registered PC. The PC is never bypassed.
//  - PC priority per cycle: rst > pc_load > pc_inc > w_en@PC_IDX > hold.
//    - Increment wraps modulo 2^DATA_W (0xFFFE+2 -> 0x0000 for DATA_W=16).
//    - pc_target bits below log2(PC_STEP) are forced to 0.
//  - Scoreboard: one busy bit per GPR. PC_IDX, and r0 when ZERO_R0=1, are never busy.
//    - w_en clears busy[w_addr]; sb_set sets busy[sb_addr].
//    - If set and clear target the same register in the same cycle, the set wins.
//    - ra_busy = busy[ra_addr] & ~(w_en & w_addr==ra_addr), so a value being
//      written this cycle is reported ready (consistent with bypass).
//    - A w_en to a non-busy register is legal; the busy bit stays 0.
//  - No X on outputs after reset; all addresses are in range by construction.
// STRUCTURE
//  - Shared package rissy_pkg holds DATA_W, NUM_REGS, ADDR_W, PC_IDX and PC_STEP
//    as localparams/constants, and reg_idx_t (ADDR_W-wide index type).
//  - One sub-module, rf_read_port, is instantiated twice. It is combinational and
//    implements the array mux, zero-reg override, bypass and busy qualification.
//  - The storage, PC and scoreboard stay in the top-level sequential logic.
// TESTING
//  1. Reset with INIT_IDX=1 -> r0..r6 read 0..6, pc=0, ra_busy=rb_busy=0.
//     Release rst, pc_inc=1 for 3 cycles -> pc = 2, 4, 6.
//  2. w_en, w_addr=3, w_data=0xBEEF, ra_addr=3 in the same cycle -> ra_data=0xBEEF
//     before the edge; after the edge, w_en=0 -> ra_data=0xBEEF.
//  3. pc_load=1, pc_target=0x1235, pc_inc=1, w_en to PC_IDX -> next pc=0x1234,
//     write dropped. Then pc=0xFFFE, pc_inc -> pc=0x0000.
//  4. sb_set r5 -> next cycle rb_addr=5 gives rb_busy=1. w_en r5 -> rb_busy=0 in
//     that same cycle. sb_set r5 with w_en r5 together -> busy stays 1.
//  5. ZERO_R0=1: write 0x00FF to r0 and sb_set r0 -> ra_data=0, ra_busy=0.
//  6. Assert rst mid-stream with busy bits set and PC=0x0040 -> next cycle all
//     busy=0, pc=PC_RESET, registers at init values.

Source files
------------

// File: rtl/rissy_pkg.sv
// Shared constants and types for the Rissy core register file.
package rissy_pkg;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int PC_IDX   = NUM_REGS - 1;
    localparam int PC_STEP  = 2;

    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/rf_read_port.sv
// Combinational read port: array mux, zero-register override, PC alias,
// write-to-read bypass and scoreboard busy qualification.
module rf_read_port #(
    parameter int DATA_W   = rissy_pkg::DATA_W,
    parameter int NUM_REGS = rissy_pkg::NUM_REGS,
    parameter int ADDR_W   = rissy_pkg::ADDR_W,
    parameter int PC_IDX   = rissy_pkg::PC_IDX,
    parameter int ZERO_R0  = 0
) (
    input  logic [DATA_W-1:0]   regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic [DATA_W-1:0]   pc,
    input  logic                w_en,
    input  logic                w_keep,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_busy
);
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic w_hit;

    assign w_hit = w_en && (w_addr == addr);

    // The PC alias wins over bypass: a PC write is only visible after the edge.
    always_comb begin
        rd_data = regs[addr];
        if ((ZERO_R0 != 0) && (addr == '0))
            rd_data = '0;
        else if (addr == PC_A)
            rd_data = pc;
        else if (w_keep && w_hit)
            rd_data = w_data;
    end

    // A register being written back this cycle is already ready to consumers.
    assign rd_busy = busy[addr] && !w_hit;
endmodule

// File: rtl/regfile_pc_sb.sv
// Rissy register file: one write port, two bypassed read ports, aliased PC
// with increment/jump, and a per-register pending-write scoreboard.
module regfile_pc_sb #(
    parameter int DATA_W   = rissy_pkg::DATA_W,
    parameter int NUM_REGS = rissy_pkg::NUM_REGS,
    parameter int ADDR_W   = rissy_pkg::ADDR_W,
    parameter int PC_IDX   = rissy_pkg::PC_IDX,
    parameter int PC_STEP  = rissy_pkg::PC_STEP,
    parameter int PC_RESET = 0,
    parameter int ZERO_R0  = 0,
    parameter int INIT_IDX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] pc,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_target,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              ra_busy,
    output logic              rb_busy
);
    localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);
    localparam int                STEP_LSB = $clog2(PC_STEP);
    localparam logic [DATA_W-1:0] PC_MASK  = ~((DATA_W'(1) << STEP_LSB) - DATA_W'(1));

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                w_drop;
    logic                w_keep;

    // PC writes lose to any PC update this cycle; r0 writes vanish when hardwired.
    assign w_drop = ((w_addr == PC_A) && (pc_load || pc_inc)) ||
                    ((ZERO_R0 != 0) && (w_addr == '0));
    assign w_keep = w_en && !w_drop;

    // Issue (set) is applied after writeback (clear) so the set wins a collision.
    always_comb begin
        busy_nxt = busy;
        if (w_en)
            busy_nxt[w_addr] = 1'b0;
        if (sb_set)
            busy_nxt[sb_addr] = 1'b1;
        busy_nxt[PC_IDX] = 1'b0;
        if (ZERO_R0 != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
            pc   <= DATA_W'(PC_RESET);
            busy <= '0;
        end else begin
            if (w_keep && (w_addr != PC_A))
                regs[w_addr] <= w_data;
            if (pc_load)
                pc <= pc_target & PC_MASK;
            else if (pc_inc)
                pc <= pc + DATA_W'(PC_STEP);
            else if (w_keep && (w_addr == PC_A))
                pc <= w_data;
            busy <= busy_nxt;
        end
    end

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .PC_IDX(PC_IDX), .ZERO_R0(ZERO_R0)
    ) u_port_a (
        .regs(regs), .busy(busy), .pc(pc),
        .w_en(w_en), .w_keep(w_keep), .w_addr(w_addr), .w_data(w_data),
        .addr(ra_addr), .rd_data(ra_data), .rd_busy(ra_busy)
    );

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .PC_IDX(PC_IDX), .ZERO_R0(ZERO_R0)
    ) u_port_b (
        .regs(regs), .busy(busy), .pc(pc),
        .w_en(w_en), .w_keep(w_keep), .w_addr(w_addr), .w_data(w_data),
        .addr(rb_addr), .rd_data(rb_data), .rd_busy(rb_busy)
    );
endmodule

// File: tb/tb_regfile_pc_sb.sv
// Bench for regfile_pc_sb: directed vector table, reset corner sequence and
// randomized traffic against an array-based reference model; two DUTs (ZERO_R0=0/1).
module tb_regfile_pc_sb;
    import rissy_pkg::*;

    localparam reg_idx_t PCA = reg_idx_t'(PC_IDX);

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    reg_idx_t    w_addr;
    logic [15:0] w_data;
    reg_idx_t    ra_addr, rb_addr;
    logic        pc_inc, pc_load;
    logic [15:0] pc_target;
    logic        sb_set;
    reg_idx_t    sb_addr;

    logic [15:0] ra_data0, rb_data0, pc0, ra_data1, rb_data1, pc1;
    logic        ra_busy0, rb_busy0, ra_busy1, rb_busy1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_pc_sb #(.ZERO_R0(0)) dut0 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data0), .rb_data(rb_data0),
        .pc(pc0), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
        .sb_set(sb_set), .sb_addr(sb_addr), .ra_busy(ra_busy0), .rb_busy(rb_busy0)
    );

    regfile_pc_sb #(.ZERO_R0(1)) dut1 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data1), .rb_data(rb_data1),
        .pc(pc1), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
        .sb_set(sb_set), .sb_addr(sb_addr), .ra_busy(ra_busy1), .rb_busy(rb_busy1)
    );

    // Reference state, index 0: plain r0, index 1: hardwired-zero r0
    logic [15:0] mreg  [2][NUM_REGS];
    logic        mbusy [2][NUM_REGS];
    logic [15:0] mpc;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic dropped(input int z);
        return ((w_addr == PCA) && (pc_load || pc_inc)) || ((z != 0) && (w_addr == 0));
    endfunction

    function automatic logic [15:0] m_read(input int z, input reg_idx_t a);
        if ((z != 0) && (a == 0)) return 16'h0000;
        if (a == PCA) return mpc;
        if (w_en && (w_addr == a) && !dropped(z)) return w_data;
        return mreg[z][a];
    endfunction

    function automatic logic m_busy(input reg_idx_t a, input int z);
        return mbusy[z][a] && !(w_en && (w_addr == a));
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < NUM_REGS; i++) begin
                mreg[z][i]  = 16'(i);
                mbusy[z][i] = 1'b0;
            end
        mpc = 16'h0000;
    endtask

    task automatic model_edge();
        logic [15:0] npc;
        if (rst) begin
            model_reset();
            return;
        end
        npc = mpc;
        if (pc_load) npc = pc_target & ~16'(PC_STEP - 1);
        else if (pc_inc) npc = mpc + 16'(PC_STEP);
        else if (w_en && (w_addr == PCA)) npc = w_data;
        for (int z = 0; z < 2; z++) begin
            if (w_en && !dropped(z) && (w_addr != PCA)) mreg[z][w_addr] = w_data;
            if (w_en) mbusy[z][w_addr] = 1'b0;
            if (sb_set && (sb_addr != PCA) && !((z != 0) && (sb_addr == 0)))
                mbusy[z][sb_addr] = 1'b1;
        end
        mpc = npc;
    endtask

    task automatic check_model();
        chk("m0_ra_data", ra_data0, m_read(0, ra_addr));
        chk("m0_rb_data", rb_data0, m_read(0, rb_addr));
        chk("m0_pc", pc0, mpc);
        chk("m0_ra_busy", 16'(ra_busy0), 16'(m_busy(ra_addr, 0)));
        chk("m0_rb_busy", 16'(rb_busy0), 16'(m_busy(rb_addr, 0)));
        chk("m1_ra_data", ra_data1, m_read(1, ra_addr));
        chk("m1_rb_data", rb_data1, m_read(1, rb_addr));
        chk("m1_pc", pc1, mpc);
        chk("m1_ra_busy", 16'(ra_busy1), 16'(m_busy(ra_addr, 1)));
        chk("m1_rb_busy", 16'(rb_busy1), 16'(m_busy(rb_addr, 1)));
    endtask

    // Inputs are already driven; check combinational outputs, then take the edge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
        pc_inc = 1'b0; pc_load = 1'b0; pc_target = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    typedef struct {
        logic        we;
        reg_idx_t    wa;
        logic [15:0] wd;
        reg_idx_t    ra;
        reg_idx_t    rb;
        logic        inc;
        logic        ld;
        logic [15:0] tgt;
        logic        sb;
        reg_idx_t    sa;
        logic [15:0] e_ra;
        logic [15:0] e_rb;
        logic [15:0] e_pc;
        logic        e_rab;
        logic        e_rbb;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd6, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0001, 16'h0006, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd7, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0002, 16'h0002, 16'h0002, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0003, 16'h0004, 16'h0004, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd7, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0004, 16'h0006, 16'h0006, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd4, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'hBEEF, 16'h0004, 16'h0006, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd4, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'hBEEF, 16'h0004, 16'h0006, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd3, 1'b1, 1'b1, 16'h1235, 1'b0, 3'd0, 16'h0006, 16'hBEEF, 16'h0006, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd3, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h1234, 16'hBEEF, 16'h1234, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd7, 16'hFFFE, 3'd7, 3'd6, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h1234, 16'h0006, 16'h1234, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd6, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'hFFFE, 16'h0006, 16'hFFFE, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd6, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0006, 16'h0000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd5, 16'h0001, 16'h0005, 16'h0000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0001, 16'h0005, 16'h0000, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 3'd5, 16'h0055, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0001, 16'h0055, 16'h0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0001, 16'h0055, 16'h0000, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 3'd5, 16'h0066, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd5, 16'h0001, 16'h0066, 16'h0000, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0001, 16'h0066, 16'h0000, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 3'd0, 16'h00FF, 3'd0, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h00FF, 16'h0066, 16'h0000, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h00FF, 16'h0066, 16'h0000, 1'b1, 1'b1};

        idle();
        ra_addr = '0;
        rb_addr = '0;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;

        // Reset state: every GPR holds its index, nothing busy, PC at reset value
        for (int i = 0; i < PC_IDX; i++) begin
            ra_addr = reg_idx_t'(i);
            rb_addr = reg_idx_t'(PC_IDX - 1 - i);
            #1;
            chk("rst_ra_data", ra_data0, 16'(i));
            chk("rst_rb_data", rb_data0, 16'(PC_IDX - 1 - i));
            chk("rst_ra_busy", 16'(ra_busy0), 16'h0000);
            chk("rst_pc", pc0, 16'h0000);
            step();
        end

        for (int i = 0; i < 20; i++) begin
            w_en = tbl[i].we; w_addr = tbl[i].wa; w_data = tbl[i].wd;
            ra_addr = tbl[i].ra; rb_addr = tbl[i].rb;
            pc_inc = tbl[i].inc; pc_load = tbl[i].ld; pc_target = tbl[i].tgt;
            sb_set = tbl[i].sb; sb_addr = tbl[i].sa;
            #1;
            chk($sformatf("vec%0d_ra_data", i), ra_data0, tbl[i].e_ra);
            chk($sformatf("vec%0d_rb_data", i), rb_data0, tbl[i].e_rb);
            chk($sformatf("vec%0d_pc", i), pc0, tbl[i].e_pc);
            chk($sformatf("vec%0d_ra_busy", i), 16'(ra_busy0), 16'(tbl[i].e_rab));
            chk($sformatf("vec%0d_rb_busy", i), 16'(rb_busy0), 16'(tbl[i].e_rbb));
            if (i >= 18) begin
                chk($sformatf("vec%0d_z_ra_data", i), ra_data1, 16'h0000);
                chk($sformatf("vec%0d_z_ra_busy", i), 16'(ra_busy1), 16'h0000);
            end
            step();
        end

        // Mid-stream reset with pending writes, busy bits and a non-reset PC
        idle();
        pc_load = 1'b1; pc_target = 16'h0040;
        step();
        idle();
        sb_set = 1'b1; sb_addr = 3'd2;
        step();
        idle();
        sb_set = 1'b1; sb_addr = 3'd3; w_en = 1'b1; w_addr = 3'd4; w_data = 16'h1111;
        ra_addr = 3'd2;
        #1;
        chk("pre_rst_busy_r2", 16'(ra_busy0), 16'h0001);
        chk("pre_rst_pc", pc0, 16'h0040);
        step();
        idle();
        rst = 1'b1; w_en = 1'b1; w_addr = 3'd4; w_data = 16'h2222;
        pc_inc = 1'b1; sb_set = 1'b1; sb_addr = 3'd1;
        step();
        idle();
        for (int i = 0; i < PC_IDX; i++) begin
            ra_addr = reg_idx_t'(i);
            rb_addr = reg_idx_t'(i);
            #1;
            chk("mid_rst_ra_data", ra_data0, 16'(i));
            chk("mid_rst_ra_busy", 16'(ra_busy0), 16'h0000);
            chk("mid_rst_z_rb_data", rb_data1, (i == 0) ? 16'h0000 : 16'(i));
            chk("mid_rst_pc", pc0, 16'h0000);
            step();
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            w_en      = ($urandom_range(0, 2) != 0);
            w_addr    = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            w_data    = 16'($urandom);
            ra_addr   = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            rb_addr   = ($urandom_range(0, 3) == 0) ? w_addr : reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            pc_inc    = ($urandom_range(0, 3) == 0);
            pc_load   = ($urandom_range(0, 7) == 0);
            pc_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            sb_set    = ($urandom_range(0, 1) == 0);
            sb_addr   = ($urandom_range(0, 3) == 0) ? w_addr : reg_idx_t'($urandom_range(0, NUM_REGS - 1));
            step();
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
